bcd_sequencer: RTL

BCD_SEQUENCER -- requirements
Module: bcd_sequencer

---
 rtl/bcd_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/bcd_sequencer.sv
// Sequential binary-to-BCD converter: one divide-by-10 per cycle, digits
// produced ones-first into a shift register and published on completion.
`ifndef INT_BITS
`define INT_BITS 32
`endif

module bcd_sequencer #(
    parameter int WIDTH  = `INT_BITS,
    parameter int DIGITS = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             value,
    output logic                         busy,
    output logic                         done,
    output logic [4*DIGITS-1:0]          digits,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits
);

    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  shreg_q, shreg_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [CW-1:0]        ndigits_q, ndigits_d;

    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem_full;
    logic [3:0]           rem;

    // Divide the working register by ten; the remainder always fits in 4 bits.
    always_comb begin
        quot     = work_q / WIDTH'(10);
        rem_full = work_q - quot * WIDTH'(10);
        rem      = rem_full[3:0];
    end

    // Next-state logic, datapath updates and status outputs.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        digits_d  = digits_q;
        ndigits_d = ndigits_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = value;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        shreg_d[4*i +: 4] = rem;
                    end
                end
                work_d = quot;
                cnt_d  = cnt_q + CW'(1);
                // Stop once nothing is left or every digit slot has been used;
                // the freshly written slot is included in the published result.
                if (quot == '0 || cnt_q == CW'(DIGITS - 1)) begin
                    state_d   = DONE;
                    digits_d  = shreg_d;
                    ndigits_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            digits_q  <= '0;
            ndigits_q <= CW'(1);
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            digits_q  <= digits_d;
            ndigits_q <= ndigits_d;
        end
    end

    assign digits  = digits_q;
    assign ndigits = ndigits_q;

endmodule
